mem_port_arbiter: RTL

- Shares a single-port unified instruction/data memory between instruction fetch (IF) and the data-memory stage (MEM) of the RV32 core.
- Decodes the control unit's mem_read/mem_write into memory transactions and sequences the req/ack handshake.
- Aborts hung transactions after a timeout.
- Drives the pipeline stall line.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a shared single-port memory with req/ack timeout
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention instead of data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_D, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_d_req, w_grant_d, w_cnt_last;
  logic               w_req_nxt, w_we_nxt, w_ifv_nxt, w_dv_nxt, w_err_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt, w_ifr_nxt, w_dr_nxt;

  assign w_d_req    = d_read | d_write;
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign stall      = (if_req & ~if_valid) | (w_d_req & ~d_valid);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;  // 0 = IF, 1 = data

  assign w_grant_d = w_d_req & ~(if_req & r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
    end else if (r_state == S_IDLE && (w_d_req || if_req)) begin
      r_last_grant <= w_grant_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = mem_req;
    w_we_nxt    = mem_we;
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = mem_wdata;
    w_ifv_nxt   = 1'b0;
    w_dv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_ifr_nxt   = if_rdata;
    w_dr_nxt    = d_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_d_req || if_req) begin
          w_req_nxt = 1'b1;
          if (w_grant_d) begin
            w_addr_nxt  = d_addr;
            w_wdata_nxt = d_wdata;
            w_we_nxt    = d_write;
            w_state_nxt = S_BUSY_D;
          end else begin
            w_addr_nxt  = if_addr;
            w_we_nxt    = 1'b0;
            w_state_nxt = S_BUSY_IF;
          end
        end
      end
      S_BUSY_IF, S_BUSY_D: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // An ack on the timeout edge still counts as a normal completion.
        if (mem_ack || w_cnt_last) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_err_nxt   = ~mem_ack;
          w_state_nxt = S_DONE;
          if (r_state == S_BUSY_IF) begin
            w_ifv_nxt = 1'b1;
            w_ifr_nxt = mem_ack ? mem_rdata : '0;
          end else begin
            w_dv_nxt = 1'b1;
            if (!mem_ack) begin
              w_dr_nxt = '0;
            end else if (!mem_we) begin
              w_dr_nxt = mem_rdata;
            end
          end
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      mem_req   <= w_req_nxt;
      mem_we    <= w_we_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      if_valid  <= w_ifv_nxt;
      d_valid   <= w_dv_nxt;
      bus_err   <= w_err_nxt;
      if_rdata  <= w_ifr_nxt;
      d_rdata   <= w_dr_nxt;
    end
  end

endmodule
